tick_gen: RTL and testbench
===========================

// Module: tick_gen
// PURPOSE
// - Programmable clock-enable (tick) generator. It sits directly upstream of the
//   8-bit counter and drives that counter's en input.
// - Produces 1-cycle tick strobes with period (div+1) clk cycles, either
//   continuously or as a burst of N ticks.
// - Start/stop/busy/done handshake for the control logic.
// PARAMETERS
// - DIV_W   16  width of the divider config and the divider counter
// - CNT_W   8   width of the burst length and the issued-tick count (matches downstream counter WIDTH)
// PORTS
// - clk        in   1      system clock, 100 MHz
// - rst        in   1      synchronous, active-high reset
// - cfg_div    in   DIV_W  tick period minus 1 (0 = tick every cycle); latched on start
// - cfg_burst  in   CNT_W  ticks per burst; 0 = continuous; latched on start
// - start      in   1      request run; honoured only in IDLE
// - stop       in   1      abort run; honoured in RUN
// - tick       out  1      registered 1-cycle enable strobe (to counter en)
// - busy       out  1      high while in RUN
// - done       out  1      1-cycle pulse when a burst completes (never on stop)
// - tick_cnt   out  CNT_W  ticks issued in the current or last run; wraps modulo 2^CNT_W
// BEHAVIOUR
// - One clock. Reset is synchronous and active-high.
// - rst high at an edge sets state=IDLE and tick=busy=done=0, tick_cnt=0,
//   div_cnt=0. This applies in any state, including mid-run.
// - States (enum): IDLE, RUN, DONE.
// - IDLE:
//   - start=1 and stop=0 at edge k: latch div_l<=cfg_div and burst_l<=cfg_burst,
//     clear div_cnt and tick_cnt, go to RUN. busy=1 after edge k.
//   - start=1 and stop=1 together in IDLE: stop wins, stay IDLE.
// - RUN, at each edge:
//   - div_cnt==div_l: tick<=1, div_cnt<=0, tick_cnt<=tick_cnt+1.
//   - otherwise: tick<=0, div_cnt<=div_cnt+1.
//   - Timing: the first tick is high in the cycle after edge k+1+div_l.
//     Subsequent ticks follow every div_l+1 cycles.
//   - Burst end: if burst_l!=0 and the tick being issued is number burst_l,
//     go to DONE on that same edge. That tick is still issued.
//   - stop=1: go to IDLE. tick<=0, no tick issued on that edge, tick_cnt held,
//     done not pulsed. stop has priority over a tick due on the same edge.
//   - start in RUN is ignored. cfg_* changes during RUN are ignored (latched values rule).
// - DONE: lasts exactly 1 cycle.
//   - done=1, busy=0, tick=0 (the final tick was the previous cycle).
//   - Next edge: go to IDLE. A start seen in DONE is ignored.
// - Continuous mode (burst_l==0): tick_cnt wraps 2^CNT_W-1 -> 0 with no state change.
//   Only stop or rst exit.
// - All outputs are registered. No combinational path from any input to any output.
// - div_l=0: tick is high every RUN cycle after the first edge.
//   div_l=2^DIV_W-1 is legal and gives period 2^DIV_W.
// STRUCTURE
// - Package tick_gen_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} tick_state_t.
// - One module with a single always_ff for state/counters.
// - Outputs are decoded from registers inside that always_ff.
// - No sub-module; the divider is a plain counter in the same process.
// TESTING
// - Reset: hold rst=1 for 5 cycles, apply start=1 during reset
//   -> tick=busy=done=0, tick_cnt=0 throughout.
// - Burst, div=0, burst=20: start one cycle
//   -> 20 back-to-back ticks, tick_cnt=20, done pulse 1 cycle after the last tick,
//      busy low from done onward.
//   Check the downstream counter q==20.
// - Period, div=3, burst=5: check tick spacing is exactly 4 cycles.
//   First tick 5 cycles after the start edge, done after tick 5, no 6th tick.
// - Stop mid-run, div=1, burst=0: stop on an edge where a tick is due
//   -> no tick that edge, IDLE, tick_cnt frozen, done stays 0.
// - Continuous wrap, div=0, burst=0, 300 cycles
//   -> tick_cnt wraps 255->0 with busy held 1.
//   Also: start+stop in the same IDLE cycle -> stays IDLE.
// - Reset mid-burst (div=2, burst=10, after 4 ticks) -> all outputs 0 next edge.
//   Fresh start after reset gives 10 ticks.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared types and defaults for the tick generator
package tick_gen_pkg;

  // Run-control states of the tick generator
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tick_state_t;

  // Default widths: divider config/counter and burst/issued-tick count
  localparam int unsigned TICK_DIV_W = 16;
  localparam int unsigned TICK_CNT_W = 8;

  // True when the tick about to be issued is the final tick of a finite burst
  function automatic logic burst_last(input logic [TICK_CNT_W-1:0] next_cnt,
                                      input logic [TICK_CNT_W-1:0] burst);
    return (burst != '0) && (next_cnt == burst);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable clock-enable strobe generator with burst/continuous modes
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned DIV_W = TICK_DIV_W,
  parameter int unsigned CNT_W = TICK_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_burst,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  tick_state_t      state_q;
  logic [DIV_W-1:0] div_l_q;
  logic [CNT_W-1:0] burst_l_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic             tick_q;
  logic             busy_q;
  logic             done_q;

  // Count after the tick currently due; wraps naturally in continuous mode
  logic [CNT_W-1:0] tick_cnt_inc;
  logic             last_tick;

  assign tick_cnt_inc = tick_cnt_q + 1'b1;
  assign last_tick    = (burst_l_q != '0) && (tick_cnt_inc == burst_l_q);

  // State, divider, tick counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_l_q    <= '0;
      burst_l_q  <= '0;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tick_q <= 1'b0;
          done_q <= 1'b0;
          // stop beats a simultaneous start so a stuck stop can never launch a run
          if (start && !stop) begin
            div_l_q    <= cfg_div;
            burst_l_q  <= cfg_burst;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end else begin
            busy_q <= 1'b0;
          end
        end

        RUN: begin
          done_q <= 1'b0;
          if (stop) begin
            // abort takes priority over a tick due on this edge; count is frozen
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (div_cnt_q == div_l_q) begin
            tick_q     <= 1'b1;
            div_cnt_q  <= '0;
            tick_cnt_q <= tick_cnt_inc;
            busy_q     <= 1'b1;
            // final tick still goes out; done/busy follow one cycle later
            if (burst_last(tick_cnt_inc, burst_l_q) && last_tick) begin
              state_q <= DONE;
            end
          end else begin
            tick_q    <= 1'b0;
            div_cnt_q <= div_cnt_q + 1'b1;
            busy_q    <= 1'b1;
          end
        end

        DONE: begin
          // single-cycle completion pulse; start is ignored here
          tick_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          tick_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tick     = tick_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - directed self-checking bench for tick_gen
module tb_tick_gen;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_burst;
  logic        start;
  logic        stop;
  logic        tick;
  logic        busy;
  logic        done;
  logic [7:0]  tick_cnt;

  // stands in for the downstream 8-bit counter driven by tick
  logic [7:0]  ds_q;

  int n_cmp;
  int n_err;

  tick_gen #(.DIV_W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_div   (cfg_div),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .tick_cnt  (tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) ds_q <= '0;
    else if (tick) ds_q <= ds_q + 8'd1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cfg_div = 16'd0; cfg_burst = 8'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({tick, busy, done, tick_cnt} !== 11'd0) begin
        n_err++;
        $display("FAIL reset cyc%0d: tick=%0b busy=%0b done=%0b cnt=%0d expected all 0", i, tick, busy, done, tick_cnt);
      end
    end
    start = 1'b0; rst = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_busy: got %0b expected 0", busy);
    end
  endtask

  task automatic test_burst();
    cfg_div = 16'd0; cfg_burst = 8'd20; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 26; n++) begin
      n_cmp++;
      if (tick !== (n >= 1 && n <= 20)) begin
        n_err++;
        $display("FAIL burst_tick n=%0d: got %0b expected %0b", n, tick, (n >= 1 && n <= 20));
      end
      n_cmp++;
      if (done !== (n == 21)) begin
        n_err++;
        $display("FAIL burst_done n=%0d: got %0b expected %0b", n, done, (n == 21));
      end
      n_cmp++;
      if (busy !== (n <= 20)) begin
        n_err++;
        $display("FAIL burst_busy n=%0d: got %0b expected %0b", n, busy, (n <= 20));
      end
      step();
    end
    n_cmp++;
    if (tick_cnt !== 8'd20) begin
      n_err++;
      $display("FAIL burst_tick_cnt: got %0d expected 20", tick_cnt);
    end
    n_cmp++;
    if (ds_q !== 8'd20) begin
      n_err++;
      $display("FAIL burst_downstream_q: got %0d expected 20", ds_q);
    end
  endtask

  task automatic test_period();
    int ticks;
    ticks = 0;
    cfg_div = 16'd3; cfg_burst = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    cfg_div = 16'd0; cfg_burst = 8'd1;
    for (int n = 0; n < 30; n++) begin
      if (tick) ticks++;
      n_cmp++;
      if (tick !== (n == 4 || n == 8 || n == 12 || n == 16 || n == 20)) begin
        n_err++;
        $display("FAIL period_tick n=%0d: got %0b", n, tick);
      end
      n_cmp++;
      if (done !== (n == 21)) begin
        n_err++;
        $display("FAIL period_done n=%0d: got %0b expected %0b", n, done, (n == 21));
      end
      step();
    end
    n_cmp++;
    if (ticks != 5) begin
      n_err++;
      $display("FAIL period_tick_total: got %0d expected 5", ticks);
    end
    n_cmp++;
    if (tick_cnt !== 8'd5) begin
      n_err++;
      $display("FAIL period_tick_cnt: got %0d expected 5", tick_cnt);
    end
  endtask

  task automatic test_stop();
    cfg_div = 16'd1; cfg_burst = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      n_cmp++;
      if (tick !== (n == 2 || n == 4)) begin
        n_err++;
        $display("FAIL stop_pre_tick n=%0d: got %0b", n, tick);
      end
      if (n == 5) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    for (int n = 6; n < 12; n++) begin
      n_cmp++;
      if ({tick, busy, done} !== 3'b000) begin
        n_err++;
        $display("FAIL stop_outputs n=%0d: tick=%0b busy=%0b done=%0b expected 000", n, tick, busy, done);
      end
      n_cmp++;
      if (tick_cnt !== 8'd2) begin
        n_err++;
        $display("FAIL stop_tick_cnt n=%0d: got %0d expected 2", n, tick_cnt);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    cfg_div = 16'd0; cfg_burst = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n <= 300; n++) begin
      if (n == 255 || n == 256 || n == 300) begin
        n_cmp++;
        if (tick_cnt !== 8'(n % 256)) begin
          n_err++;
          $display("FAIL wrap_cnt n=%0d: got %0d expected %0d", n, tick_cnt, n % 256);
        end
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_busy n=%0d: busy=%0b done=%0b expected 1 0", n, busy, done);
        end
      end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_stop_busy: got %0b expected 0", busy);
    end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if ({tick, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL start_stop_idle n=%0d: tick=%0b busy=%0b expected 00", n, tick, busy);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int ticks;
    int dones;
    cfg_div = 16'd2; cfg_burst = 8'd10; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 12; n++) step();
    n_cmp++;
    if (tick !== 1'b1 || tick_cnt !== 8'd4) begin
      n_err++;
      $display("FAIL rstmid_pre: tick=%0b cnt=%0d expected 1 4", tick, tick_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({tick, busy, done, tick_cnt} !== 11'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs: tick=%0b busy=%0b done=%0b cnt=%0d expected all 0", tick, busy, done, tick_cnt);
    end
    ticks = 0; dones = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (tick) ticks++;
      if (done) dones++;
      step();
    end
    n_cmp++;
    if (ticks != 10) begin
      n_err++;
      $display("FAIL rstmid_fresh_ticks: got %0d expected 10", ticks);
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL rstmid_fresh_done: got %0d expected 1", dones);
    end
    n_cmp++;
    if (tick_cnt !== 8'd10 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_fresh_end: cnt=%0d busy=%0b expected 10 0", tick_cnt, busy);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_div = '0; cfg_burst = '0;
    @(negedge clk);
    test_reset();
    test_burst();
    test_period();
    test_stop();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
